rv16_mem_arbiter: RTL and testbench
===================================

Name: rv16_mem_arbiter

Overview:
- Shares the single RV16 memory port between the instruction-fetch requester and the IDE-stage data (load/store) requester.
- Fixed priority: data over fetch, with a starvation guard for fetch.
- One outstanding transaction at a time; the latched request is held stable on the memory bus until i_mem_ready.
- Sits between the fetch unit, the IDE stage and the memory interface.

Parameters:
- MAX_STARVE, 4, max consecutive data grants while fetch is pending before fetch is forced (1..15).
- TIMEOUT, 255, cycles to wait for i_mem_ready before abort; used only with RV16_ARB_TIMEOUT_EN (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_if_req  in  1  fetch request, held until done.
- i_if_addr  in  32  fetch address.
- o_if_done  out  1  fetch completes this cycle.
- o_if_rdata  out  32  fetch data, valid when o_if_done.
- i_d_req  in  1  data request, held until done.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  32  data address.
- i_d_wdata  in  32  store data.
- i_d_size  in  3  access size (funct3 encoding).
- o_d_done  out  1  data access completes this cycle.
- o_d_rdata  out  32  load data, valid when o_d_done.
- o_err  out  1  completing access was aborted; qualifies either done.
- o_mem_addr  out  32  memory address.
- o_mem_wdata  out  32  memory write data.
- o_mem_read  out  1  memory read strobe.
- o_mem_write  out  1  memory write strobe.
- o_mem_size  out  3  memory access size.
- i_mem_rdata  in  32  memory read data.
- i_mem_ready  in  1  memory completes the current access.
- o_busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, FETCH, DATA.
- Reset (async, immediate): state=IDLE; starve_cnt=0; latched addr/wdata/size/we = 0; o_mem_read=o_mem_write=0; all done/err=0; o_busy=0.
- IDLE arbitration (requests sampled only in IDLE):
  - d_req && (!if_req || starve_cnt<MAX_STARVE) -> DATA.
  - else if_req -> FETCH.
  - else stay in IDLE.
- Grant edge: latch the winner's addr, wdata, size and we into registers.
  - Fetch grants latch size=3'b010, we=0, wdata=0.
- starve_cnt update:
  - Increments (saturating) on a DATA grant while if_req=1.
  - Clears on a FETCH grant, or in any IDLE cycle with if_req=0.
- While in FETCH/DATA:
  - o_mem_addr/wdata/size driven from the latched registers.
  - o_mem_read = !we_latched.
  - o_mem_write = we_latched.
  - In IDLE both strobes are 0; addr/wdata/size hold their last values.
- Completion: in FETCH/DATA with i_mem_ready=1:
  - o_if_done or o_d_done = 1 combinationally in that same cycle.
  - o_*_rdata = i_mem_rdata (pass-through), 0 for stores.
  - Next state is IDLE.
- Done is a single cycle. The requester drops its req at that edge; a req still high in the following IDLE cycle is a new request.
- Minimum cost is 2 cycles per access (grant cycle + ready cycle). Back-to-back accesses have one IDLE arbitration cycle between them.
- Request inputs changing while granted are ignored (latched copy is used).
- Reset asserted mid-transaction: strobes drop asynchronously; no done is issued; the requester must re-request.
- Requesting both sides with starve_cnt==MAX_STARVE: fetch wins, counter clears.

Optional Feature:
- Macro: RV16_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on every grant and increments each FETCH/DATA cycle without ready.
  - When it reaches TIMEOUT-1 with no ready: the corresponding done pulses with o_err=1 and rdata=0; strobes drop; state -> IDLE.
  - Ready arriving on that same cycle wins: normal completion, o_err=0.
- Undefined: waits indefinitely; no counter exists; o_err tied to 0.

Test Plan:
- Fetch only, i_if_addr=0x0000_0040, ready 2 cycles after grant, rdata=0x00A5_0513 -> o_mem_read=1 and addr=0x40 for 2 cycles; o_if_done=1 with o_if_rdata=0x00A5_0513 in the ready cycle; o_mem_read=0 next cycle.
- Simultaneous if_req and d_req store: addr 0x100, wdata 0xDEAD_BEEF, size 3'b010, ready immediate -> DATA first, o_mem_write=1 with 0xDEAD_BEEF, o_d_done; one IDLE cycle; then FETCH granted.
- d_req held continuously with immediate ready, if_req held -> grants D,D,D,D,F (MAX_STARVE=4); starve_cnt returns to 0 after F.
- Load granted, rst pulsed before ready -> o_mem_read falls within the rst cycle without a clock edge; no o_d_done; o_busy=0; a new d_req is granted normally after rst drops.
- With RV16_ARB_TIMEOUT_EN and TIMEOUT=8, load with ready held 0 -> o_d_done=1, o_err=1, o_d_rdata=0 at the 8th DATA cycle; then IDLE.
- With RV16_ARB_TIMEOUT_EN, ready on the 8th cycle -> normal completion with o_err=0.

Source files
------------

// File: rtl/rv16_mem_arbiter.sv
// rv16_mem_arbiter: shares the single RV16 memory port between the fetch unit
// and the IDE-stage load/store requester. Data has fixed priority over fetch.
// A starvation guard forces a fetch grant after MAX_STARVE consecutive data
// grants while fetch is waiting. Only one transaction is outstanding at a time.
// The granted request is latched and held on the memory bus until i_mem_ready.
//
// Optional feature macro: RV16_ARB_TIMEOUT_EN
//   When defined, an access that sees no i_mem_ready for TIMEOUT cycles is
//   aborted: its done pulses with o_err=1 and rdata=0.
//   When undefined, the arbiter waits indefinitely and o_err is tied to 0.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   i_if_req/i_if_addr            fetch request, held until o_if_done
//   o_if_done/o_if_rdata          fetch completion and data (same cycle as ready)
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata/i_d_size            data request, held until o_d_done
//   o_d_done/o_d_rdata            data completion and load data
//   o_err                         completing access was aborted (timeout)
//   o_mem_addr/wdata/read/write/size   memory request, from latched registers
//   i_mem_rdata/i_mem_ready       memory response
//   o_busy                        a transaction is in flight
module rv16_mem_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_done,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [2:0]  i_d_size,
    output logic        o_d_done,
    output logic [31:0] o_d_rdata,
    output logic        o_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [2:0]  o_mem_size,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic        o_busy
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned WAIT_W   = 8;

    // Elaboration-time parameter range guards
    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("rv16_mem_arbiter: MAX_STARVE must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rv16_mem_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic [STARVE_W-1:0]   w_starve_nxt;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_size;
    logic                  r_we;

    logic                  w_idle;
    logic                  w_active;
    logic                  w_grant_d;
    logic                  w_grant_f;
    logic                  w_complete;
    logic                  w_abort;
    logic                  w_finish;

    // Arbitration: data wins unless fetch has been starved MAX_STARVE times
    assign w_idle    = (r_state == S_IDLE);
    assign w_active  = !w_idle;
    assign w_grant_d = w_idle && i_d_req &&
                       (!i_if_req || (r_starve_cnt < STARVE_W'(MAX_STARVE)));
    assign w_grant_f = w_idle && !w_grant_d && i_if_req;

    assign w_complete = w_active && i_mem_ready;
    assign w_finish   = w_complete || w_abort;

`ifdef RV16_ARB_TIMEOUT_EN
    logic [WAIT_W-1:0] r_wait;

    // Wait counter: cleared on grant, counts active cycles without ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_grant_d || w_grant_f) begin
            r_wait <= '0;
        end else if (w_active && !i_mem_ready) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Ready on the final allowed cycle still completes normally
    assign w_abort = w_active && !i_mem_ready && (r_wait == WAIT_W'(TIMEOUT - 1));
`else
    assign w_abort = 1'b0;
`endif

    // State, starvation counter and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_we         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (w_grant_d) begin
                r_addr  <= i_d_addr;
                r_wdata <= i_d_wdata;
                r_size  <= i_d_size;
                r_we    <= i_d_we;
            end else if (w_grant_f) begin
                r_addr  <= i_if_addr;
                r_wdata <= '0;
                r_size  <= 3'b010;
                r_we    <= 1'b0;
            end
        end
    end

    // Next-state and starvation counter update
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_DATA;
                    if (i_if_req && (r_starve_cnt != {STARVE_W{1'b1}})) begin
                        w_starve_nxt = r_starve_cnt + STARVE_W'(1);
                    end
                end else if (w_grant_f) begin
                    w_state_nxt  = S_FETCH;
                    w_starve_nxt = '0;
                end
                // No fetch waiting means nothing is being starved
                if (!i_if_req) begin
                    w_starve_nxt = '0;
                end
            end
            S_FETCH, S_DATA: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory bus: strobes only while a transaction is in flight
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_size  = r_size;
    assign o_mem_read  = w_active && !r_we;
    assign o_mem_write = w_active && r_we;
    assign o_busy      = w_active;

    // Completion is combinational with i_mem_ready (or abort)
    assign o_if_done  = (r_state == S_FETCH) && w_finish;
    assign o_d_done   = (r_state == S_DATA) && w_finish;
    assign o_err      = w_abort;
    assign o_if_rdata = (o_if_done && !w_abort) ? i_mem_rdata : 32'h0;
    assign o_d_rdata  = (o_d_done && !w_abort && !r_we) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_rv16_mem_arbiter.sv
// tb_rv16_mem_arbiter: directed self-checking bench for rv16_mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well before the next rising edge.
module tb_rv16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_done;
    logic [31:0] o_if_rdata;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [2:0]  i_d_size;
    logic        o_d_done;
    logic [31:0] o_d_rdata;
    logic        o_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [2:0]  o_mem_size;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ready;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    rv16_mem_arbiter #(
        .MAX_STARVE (4),
        .TIMEOUT    (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_done   (o_if_done),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .i_d_size    (i_d_size),
        .o_d_done    (o_d_done),
        .o_d_rdata   (o_d_rdata),
        .o_err       (o_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .o_mem_size  (o_mem_size),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        i_if_req    = 1'b0;
        i_if_addr   = 32'h0;
        i_d_req     = 1'b0;
        i_d_we      = 1'b0;
        i_d_addr    = 32'h0;
        i_d_wdata   = 32'h0;
        i_d_size    = 3'b000;
        i_mem_rdata = 32'h0;
        i_mem_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_read",  32'(o_mem_read), 32'd0);
        chk("rst_write", 32'(o_mem_write), 32'd0);
        chk("rst_ddone", 32'(o_d_done), 32'd0);
        chk("rst_ifdone",32'(o_if_done), 32'd0);
        chk("rst_addr",  o_mem_addr, 32'h0);
        rst = 1'b0;

        // Fetch only, ready two cycles after grant
        step();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0040;
        #1;
        chk("f1_idle_busy", 32'(o_busy), 32'd0);
        step();
        #1;
        chk("f1_c1_read", 32'(o_mem_read), 32'd1);
        chk("f1_c1_addr", o_mem_addr, 32'h40);
        chk("f1_c1_size", 32'(o_mem_size), 32'd2);
        chk("f1_c1_done", 32'(o_if_done), 32'd0);
        step();
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'h00A5_0513;
        #1;
        chk("f1_c2_read",  32'(o_mem_read), 32'd1);
        chk("f1_c2_done",  32'(o_if_done), 32'd1);
        chk("f1_c2_rdata", o_if_rdata, 32'h00A5_0513);
        chk("f1_c2_ddone", 32'(o_d_done), 32'd0);
        chk("f1_c2_err",   32'(o_err), 32'd0);
        step();
        i_if_req    = 1'b0;
        i_mem_ready = 1'b0;
        #1;
        chk("f1_after_read", 32'(o_mem_read), 32'd0);
        chk("f1_after_busy", 32'(o_busy), 32'd0);
        chk("f1_after_addr", o_mem_addr, 32'h40);

        // Simultaneous requests: data store first, then fetch
        step();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0200;
        i_d_req   = 1'b1;
        i_d_we    = 1'b1;
        i_d_addr  = 32'h0000_0100;
        i_d_wdata = 32'hDEAD_BEEF;
        i_d_size  = 3'b010;
        step();
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'h1234_5678;
        #1;
        chk("s2_write",  32'(o_mem_write), 32'd1);
        chk("s2_read",   32'(o_mem_read), 32'd0);
        chk("s2_addr",   o_mem_addr, 32'h100);
        chk("s2_wdata",  o_mem_wdata, 32'hDEAD_BEEF);
        chk("s2_ddone",  32'(o_d_done), 32'd1);
        chk("s2_ifdone", 32'(o_if_done), 32'd0);
        chk("s2_drdata", o_d_rdata, 32'h0);
        step();
        i_d_req     = 1'b0;
        i_d_we      = 1'b0;
        i_mem_ready = 1'b0;
        #1;
        chk("s2_gap_busy", 32'(o_busy), 32'd0);
        step();
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'h1111_2222;
        #1;
        chk("s2_f_read",   32'(o_mem_read), 32'd1);
        chk("s2_f_addr",   o_mem_addr, 32'h200);
        chk("s2_f_wdata",  o_mem_wdata, 32'h0);
        chk("s2_f_done",   32'(o_if_done), 32'd1);
        chk("s2_f_rdata",  o_if_rdata, 32'h1111_2222);
        step();
        i_if_req    = 1'b0;
        i_mem_ready = 1'b0;

        // Starvation guard: D,D,D,D,F repeated twice with both reqs held
        step();
        i_if_req    = 1'b1;
        i_if_addr   = 32'h0000_0400;
        i_d_req     = 1'b1;
        i_d_we      = 1'b0;
        i_d_addr    = 32'h0000_0300;
        i_d_size    = 3'b010;
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'h5555_AAAA;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (k != 0) begin
                step();
                #1;
            end
            if ((k % 2) == 0) begin
                chk($sformatf("st_k%0d_busy", k), 32'(o_busy), 32'd0);
                chk($sformatf("st_k%0d_dd", k), 32'(o_d_done), 32'd0);
            end else if ((((k - 1) / 2) % 5) == 4) begin
                chk($sformatf("st_k%0d_fd", k), 32'(o_if_done), 32'd1);
                chk($sformatf("st_k%0d_dd", k), 32'(o_d_done), 32'd0);
                chk($sformatf("st_k%0d_addr", k), o_mem_addr, 32'h400);
            end else begin
                chk($sformatf("st_k%0d_dd", k), 32'(o_d_done), 32'd1);
                chk($sformatf("st_k%0d_fd", k), 32'(o_if_done), 32'd0);
                chk($sformatf("st_k%0d_addr", k), o_mem_addr, 32'h300);
            end
        end
        step();
        i_if_req    = 1'b0;
        i_d_req     = 1'b0;
        i_mem_ready = 1'b0;

        // Reset in the middle of a load
        step();
        i_d_req  = 1'b1;
        i_d_we   = 1'b0;
        i_d_addr = 32'h0000_0500;
        i_d_size = 3'b100;
        step();
        #1;
        chk("r4_read", 32'(o_mem_read), 32'd1);
        chk("r4_size", 32'(o_mem_size), 32'd4);
        chk("r4_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("r4_rst_read", 32'(o_mem_read), 32'd0);
        chk("r4_rst_busy", 32'(o_busy), 32'd0);
        chk("r4_rst_done", 32'(o_d_done), 32'd0);
        chk("r4_rst_addr", o_mem_addr, 32'h0);
        #1;
        rst = 1'b0;
        step();
        #1;
        chk("r4_re_busy", 32'(o_busy), 32'd1);
        chk("r4_re_read", 32'(o_mem_read), 32'd1);
        chk("r4_re_addr", o_mem_addr, 32'h500);
        step();
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'hA5A5_A5A5;
        #1;
        chk("r4_re_done",  32'(o_d_done), 32'd1);
        chk("r4_re_rdata", o_d_rdata, 32'hA5A5_A5A5);
        step();
        i_d_req     = 1'b0;
        i_mem_ready = 1'b0;

`ifdef RV16_ARB_TIMEOUT_EN
        // Timeout abort on the 8th DATA cycle
        step();
        i_d_req     = 1'b1;
        i_d_addr    = 32'h0000_0600;
        i_mem_rdata = 32'h7777_7777;
        for (int c = 1; c <= 8; c++) begin
            step();
            #1;
            if (c < 8) begin
                chk($sformatf("to_c%0d_done", c), 32'(o_d_done), 32'd0);
            end else begin
                chk("to_done",  32'(o_d_done), 32'd1);
                chk("to_err",   32'(o_err), 32'd1);
                chk("to_rdata", o_d_rdata, 32'h0);
            end
        end
        step();
        i_d_req = 1'b0;
        #1;
        chk("to_after_busy", 32'(o_busy), 32'd0);
        chk("to_after_read", 32'(o_mem_read), 32'd0);

        // Ready on the 8th cycle wins over the timeout
        step();
        i_d_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin
                i_mem_ready = 1'b1;
            end
            #1;
            if (c == 8) begin
                chk("tr_done",  32'(o_d_done), 32'd1);
                chk("tr_err",   32'(o_err), 32'd0);
                chk("tr_rdata", o_d_rdata, 32'h7777_7777);
            end
        end
        step();
        i_d_req     = 1'b0;
        i_mem_ready = 1'b0;
`else
        // Without the timeout feature the arbiter waits indefinitely
        step();
        i_d_req     = 1'b1;
        i_d_addr    = 32'h0000_0600;
        i_mem_rdata = 32'h7777_7777;
        for (int c = 1; c <= 20; c++) begin
            step();
            #1;
            chk($sformatf("nt_c%0d_done", c), 32'(o_d_done | o_err), 32'd0);
        end
        step();
        i_mem_ready = 1'b1;
        #1;
        chk("nt_done",  32'(o_d_done), 32'd1);
        chk("nt_err",   32'(o_err), 32'd0);
        chk("nt_rdata", o_d_rdata, 32'h7777_7777);
        step();
        i_d_req     = 1'b0;
        i_mem_ready = 1'b0;
`endif

        step();
        #1;
        chk("end_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
